// File: rtl/intr_pkg.sv
// Shared constants and types for the 27-channel interrupt scheduler.
//   NCH  : channels per request bus
//   NBUS : number of request buses (priority order A, B, C)
//   NVEC : total channel count, also the width of mask/pend
//   VW   : vector width, wide enough for NVEC-1
package intr_pkg;
  localparam int NCH  = 9;
  localparam int NBUS = 3;
  localparam int NVEC = NBUS * NCH;
  localparam int VW   = 5;

  localparam int BUS_A = 0;
  localparam int BUS_B = 1;
  localparam int BUS_C = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;
endpackage

// File: rtl/intr_sched27_if.sv
// Request/handshake bundle between peripherals + CPU and the scheduler.
//   id_req_a/b/c : per-bus request lines (level, rising edge is the event)
//   id_mask      : 1 = channel blocked, [8:0]=A, [17:9]=B, [26:18]=C
//   id_ack       : CPU acknowledge of the presented vector
//   id_eoi       : CPU end-of-interrupt pulse
//   id_irq       : interrupt request to the CPU
//   id_vec       : winning vector, bus*9 + chan
//   id_busy      : scheduler is issuing or servicing
//   id_pend      : pending latches, same bit map as id_mask
// master = requesters/CPU side, slave = scheduler side.
interface intr_sched27_if;
  import intr_pkg::*;

  logic [NCH-1:0]  id_req_a;
  logic [NCH-1:0]  id_req_b;
  logic [NCH-1:0]  id_req_c;
  logic [NVEC-1:0] id_mask;
  logic            id_ack;
  logic            id_eoi;
  logic            id_irq;
  logic [VW-1:0]   id_vec;
  logic            id_busy;
  logic [NVEC-1:0] id_pend;

  modport master (
    output id_req_a, id_req_b, id_req_c, id_mask, id_ack, id_eoi,
    input  id_irq, id_vec, id_busy, id_pend
  );

  modport slave (
    input  id_req_a, id_req_b, id_req_c, id_mask, id_ack, id_eoi,
    output id_irq, id_vec, id_busy, id_pend
  );
endinterface

// File: rtl/intr_prio_enc27.sv
// Fixed-priority encoder over the 27 eligible channels.
//   elig  : eligible channels, [8:0]=A, [17:9]=B, [26:18]=C
//   vec   : bus*NCH + chan of the highest-priority set bit (0 if none)
//   valid : at least one channel is eligible
// Bus A beats B beats C; within a bus channel 0 is highest.
module intr_prio_enc27
  import intr_pkg::*;
(
  input  logic [NVEC-1:0] elig,
  output logic [VW-1:0]   vec,
  output logic            valid
);

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch is inferred.
    vec   = '0;
    valid = 1'b0;
    for (int b = NBUS - 1; b >= 0; b--) begin
      for (int c = NCH - 1; c >= 0; c--) begin
        if (elig[b*NCH + c]) begin
          vec   = VW'(b*NCH + c);
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/intr_sched27.sv
// 27-channel interrupt scheduler (buses A, B, C x 9 channels).
//   id_clk  : clock, all state on the rising edge
//   id_rstn : asynchronous active-low reset
//   bus     : slave side of intr_sched27_if (requests, mask, ack/eoi in;
//             irq, vec, busy, pend out)
// Rising request edges latch into pend; pend & ~mask competes in a fixed
// priority encoder; the winner is presented with irq until ack, then the
// scheduler waits for eoi before choosing again.
module intr_sched27
  import intr_pkg::*;
(
  input  logic          id_clk,
  input  logic          id_rstn,
  intr_sched27_if.slave bus
);

  logic [NVEC-1:0] req_all;
  logic [NVEC-1:0] hist_q, hist_d;
  logic [NVEC-1:0] pend_q, pend_d;
  logic [NVEC-1:0] rise;
  logic [NVEC-1:0] clr;
  logic [NVEC-1:0] elig;
  state_e          state_q, state_d;
  logic            irq_q, irq_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic            busy_q, busy_d;
  logic [VW-1:0]   enc_vec;
  logic            enc_valid;

  assign req_all = {bus.id_req_c, bus.id_req_b, bus.id_req_a};
  // History is cleared by reset, so a line already high at release is an edge.
  assign rise    = req_all & ~hist_q;
  assign elig    = pend_q & ~bus.id_mask;

  intr_prio_enc27 u_prio_enc (
    .elig  (elig),
    .vec   (enc_vec),
    .valid (enc_valid)
  );

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    clr     = '0;
    case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          state_d = ST_ISSUE;
          vec_d   = enc_vec;
          irq_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_ISSUE: begin
        // irq/vec are frozen here; mask changes or new winners wait.
        // eoi is not looked at, so ack+eoi together acts as ack only.
        if (bus.id_ack) begin
          clr     = NVEC'(1) << vec_q;
          irq_d   = 1'b0;
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (bus.id_eoi) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        irq_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    // A new edge on the channel being acknowledged wins over its clear.
    pend_d = (pend_q & ~clr) | rise;
    hist_d = req_all;
  end

  always_ff @(posedge id_clk or negedge id_rstn) begin
    if (!id_rstn) begin
      state_q <= ST_IDLE;
      hist_q  <= '0;
      pend_q  <= '0;
      irq_q   <= 1'b0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= state_d;
      hist_q  <= hist_d;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.id_irq  = irq_q;
  assign bus.id_vec  = vec_q;
  assign bus.id_busy = busy_q;
  assign bus.id_pend = pend_q;

endmodule

// File: tb/tb_intr_sched27.sv
// Self-checking bench for intr_sched27: directed scenarios followed by
// randomized traffic. Each cycle the driver advances a behavioural model and
// queues the expected outputs; a monitor pops and compares after each edge.
module tb_intr_sched27;
  import intr_pkg::*;

  typedef struct {
    logic        irq;
    logic [4:0]  vec;
    logic        busy;
    logic [26:0] pend;
  } exp_t;

  logic clk;
  logic rstn;
  intr_sched27_if bus_if();

  intr_sched27 dut (
    .id_clk  (clk),
    .id_rstn (rstn),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  exp_t exp_q[$];

  // Behavioural model state
  logic [26:0] m_pend, m_hist;
  int          m_phase;   // 0 waiting, 1 presenting, 2 in service
  logic        m_irq, m_busy;
  logic [4:0]  m_vec;

  // Current stimulus levels
  logic [26:0] cur_req, cur_mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [26:0] req, input logic [26:0] mask,
                            input logic ack, input logic eoi, input logic rst_ok);
    logic [26:0] rise, served;
    int win;
    if (!rst_ok) begin
      m_pend = '0; m_hist = '0; m_phase = 0;
      m_irq = 1'b0; m_vec = '0; m_busy = 1'b0;
    end else begin
      rise   = req & ~m_hist;
      served = '0;
      if (m_phase == 0) begin
        win = -1;
        for (int i = 0; i < 27; i++)
          if (win < 0 && m_pend[i] && !mask[i]) win = i;
        if (win >= 0) begin
          m_vec = 5'(win); m_irq = 1'b1; m_busy = 1'b1; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (ack) begin
          served[m_vec] = 1'b1; m_irq = 1'b0; m_phase = 2;
        end
      end else if (eoi) begin
        m_phase = 0; m_busy = 1'b0;
      end
      m_pend = (m_pend & ~served) | rise;
      m_hist = req;
    end
  endtask

  // One clock: drive at the falling edge, predict, then wait past the rising edge.
  task automatic step(input logic ack = 1'b0, input logic eoi = 1'b0, input logic r = 1'b1);
    exp_t e;
    @(negedge clk);
    rstn            = r;
    bus_if.id_req_a = cur_req[8:0];
    bus_if.id_req_b = cur_req[17:9];
    bus_if.id_req_c = cur_req[26:18];
    bus_if.id_mask  = cur_mask;
    bus_if.id_ack   = ack;
    bus_if.id_eoi   = eoi;
    model_step(cur_req, cur_mask, ack, eoi, r);
    e.irq = m_irq; e.vec = m_vec; e.busy = m_busy; e.pend = m_pend;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic serve();
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
  endtask

  // Monitor: compare every registered output after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_irq",  32'(bus_if.id_irq),  32'(e.irq));
      check("sb_vec",  32'(bus_if.id_vec),  32'(e.vec));
      check("sb_busy", 32'(bus_if.id_busy), 32'(e.busy));
      check("sb_pend", 32'(bus_if.id_pend), 32'(e.pend));
    end
  end

  initial begin
    rstn = 1'b0;
    cur_req = '1; cur_mask = '0;
    bus_if.id_req_a = '1; bus_if.id_req_b = '1; bus_if.id_req_c = '1;
    bus_if.id_mask = '0; bus_if.id_ack = 1'b0; bus_if.id_eoi = 1'b0;
    model_step('0, '0, 1'b0, 1'b0, 1'b0);

    // Reset with all requests high, then release.
    step(0, 0, 0);
    step(0, 0, 0);
    check("rst_irq",  32'(bus_if.id_irq),  0);
    check("rst_pend", 32'(bus_if.id_pend), 0);
    check("rst_busy", 32'(bus_if.id_busy), 0);
    step();
    check("rel_pend", 32'(bus_if.id_pend), 32'h7FF_FFFF);
    check("rel_irq0", 32'(bus_if.id_irq),  0);
    step();
    check("rel_irq",  32'(bus_if.id_irq),  1);
    check("rel_vec",  32'(bus_if.id_vec),  0);

    cur_req = '0;
    step(0, 0, 0);
    step();
    step();

    // Priority: C3 and B8 together.
    cur_req[21] = 1'b1; cur_req[17] = 1'b1;
    step();
    cur_req = '0;
    step();
    check("prio_vec1", 32'(bus_if.id_vec), 17);
    check("prio_irq1", 32'(bus_if.id_irq), 1);
    serve();
    step();
    check("prio_vec2", 32'(bus_if.id_vec), 21);
    check("prio_irq2", 32'(bus_if.id_irq), 1);
    serve();
    step();

    // Mask blocks but keeps pend.
    cur_mask[0] = 1'b1;
    cur_req[0] = 1'b1;
    step();
    cur_req[0] = 1'b0;
    check("mask_pend", 32'(bus_if.id_pend[0]), 1);
    step(); step(); step();
    check("mask_irq", 32'(bus_if.id_irq), 0);
    cur_mask[0] = 1'b0;
    step();
    check("unmask_irq", 32'(bus_if.id_irq), 1);
    check("unmask_vec", 32'(bus_if.id_vec), 0);
    serve();
    step();

    // Handshake hold with a late higher-priority arrival.
    cur_req[5] = 1'b1;
    step();
    cur_req[5] = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      cur_req[0] = (i == 4);
      step();
    end
    check("hold_vec", 32'(bus_if.id_vec), 5);
    check("hold_irq", 32'(bus_if.id_irq), 1);
    step(1'b1, 1'b0);
    check("ack_irq",  32'(bus_if.id_irq),     0);
    check("ack_busy", 32'(bus_if.id_busy),    1);
    check("ack_pend", 32'(bus_if.id_pend[5]), 0);
    step(1'b0, 1'b1);
    step();
    check("next_irq", 32'(bus_if.id_irq), 1);
    check("next_vec", 32'(bus_if.id_vec), 0);
    serve();
    step();

    // Set/clear collision on B2 (vector 11).
    cur_req[11] = 1'b1;
    step();
    cur_req[11] = 1'b0;
    step();
    check("coll_vec", 32'(bus_if.id_vec), 11);
    cur_req[11] = 1'b1;
    step(1'b1, 1'b0);
    cur_req[11] = 1'b0;
    check("coll_pend", 32'(bus_if.id_pend[11]), 1);
    step(1'b0, 1'b1);
    step();
    check("coll_revec", 32'(bus_if.id_vec), 11);
    check("coll_reirq", 32'(bus_if.id_irq), 1);
    serve();
    step();

    // Reset during SERVICE, then stray ack/eoi.
    cur_req[3] = 1'b1;
    step();
    cur_req[3] = 1'b0;
    step();
    step(1'b1, 1'b0);
    check("svc_busy", 32'(bus_if.id_busy), 1);
    step(0, 0, 0);
    check("mid_busy", 32'(bus_if.id_busy), 0);
    check("mid_pend", 32'(bus_if.id_pend), 0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check("stray_irq",  32'(bus_if.id_irq),  0);
    check("stray_busy", 32'(bus_if.id_busy), 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic a, e, r;
      cur_req = cur_req ^ ($urandom() & $urandom() & $urandom());
      if ($urandom_range(0, 19) == 0)
        cur_mask = 27'($urandom() & $urandom() & $urandom());
      a = ($urandom_range(0, 2) == 0);
      e = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 499) != 0);
      step(a, e, r);
    end

    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
